mem_rr_arbiter: RTL

- Two-requester round-robin arbiter that shares one single-port `memory` instance (valid/ready, wr_rd select) between two masters.
- Each master port uses the same handshake as the memory. The arbiter captures the winning request and replays it to the memory.
- It returns ready and read data to the winner only, and flags memory stalls via a watchdog timeout.

---
 rtl/mem_rr_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Shares one single-port memory (valid/ready, wr_rd select) between two
//   masters. An IDLE cycle picks a winner: the only requester, or the
//   master named by the round-robin pointer when both ask. The winner's
//   request is captured into memory-side registers and replayed. The
//   completion (ready, read data, timeout error) is returned to the winner
//   only. A watchdog aborts a transfer that waits too long for mem_ready_i.
//
// Ports
//   clk_i, rst_i                        clock, synchronous active-high reset
//   mX_valid_i/wr_rd_i/addr_i/wdata_i   master X request (X = 0, 1)
//   mX_rdata_o/ready_o/err_o            master X completion
//   mem_valid_o/wr_rd_o/addr_o/wdata_o  request replayed to the memory
//   mem_rdata_i/ready_i                 memory response
//   grant_o                             one-hot owner while BUSY, 00 in IDLE
module mem_rr_arbiter #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_valid_i,
    input  logic                  m0_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WIDTH-1:0]      m0_wdata_i,
    output logic [WIDTH-1:0]      m0_rdata_o,
    output logic                  m0_ready_o,
    output logic                  m0_err_o,
    input  logic                  m1_valid_i,
    input  logic                  m1_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WIDTH-1:0]      m1_wdata_i,
    output logic [WIDTH-1:0]      m1_rdata_o,
    output logic                  m1_ready_o,
    output logic                  m1_err_o,
    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic [1:0]            grant_o
);
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;   // 0 = master 0, 1 = master 1
    logic                  ptr_q,   ptr_d;     // preferred master on a tie
    logic [WD_W-1:0]       wdog_q,  wdog_d;
    logic                  wr_q,    wr_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;

    logic timeout_hit;
    logic done;
    logic win;

    assign timeout_hit = (wdog_q == WD_W'(TIMEOUT - 1));
    // Transfer ends this cycle, either by handshake or by watchdog abort.
    assign done = (state_q == BUSY) && (mem_ready_i || timeout_hit);
    // Winner when arbitrating: pointer breaks a tie, otherwise the requester.
    assign win  = (m0_valid_i && m1_valid_i) ? ptr_q : m1_valid_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            wdog_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    state_d = BUSY;
                    owner_d = win;
                    wdog_d  = '0;
                    wr_d    = win ? m1_wr_rd_i : m0_wr_rd_i;
                    addr_d  = win ? m1_addr_i  : m0_addr_i;
                    wdata_d = win ? m1_wdata_i : m0_wdata_i;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    ptr_d   = ~owner_q;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Completion is suppressed in a reset cycle so that a
    // reset during BUSY abandons the transfer without any pulse.
    always_comb begin
        logic [WIDTH-1:0] rd;
        rd          = (mem_ready_i && !wr_q) ? mem_rdata_i : '0;
        m0_ready_o  = 1'b0;
        m0_err_o    = 1'b0;
        m0_rdata_o  = '0;
        m1_ready_o  = 1'b0;
        m1_err_o    = 1'b0;
        m1_rdata_o  = '0;
        grant_o     = 2'b00;
        mem_valid_o = (state_q == BUSY);
        mem_wr_rd_o = wr_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (state_q == BUSY) grant_o = owner_q ? 2'b10 : 2'b01;
        if (done && !rst_i) begin
            if (owner_q) begin
                m1_ready_o = 1'b1;
                m1_err_o   = !mem_ready_i;
                m1_rdata_o = rd;
            end else begin
                m0_ready_o = 1'b1;
                m0_err_o   = !mem_ready_i;
                m0_rdata_o = rd;
            end
        end
    end
endmodule
